// File: rtl/rank_sort_param_pkg.sv
// Shared types and helpers for the rank sorter: one-hot FSM encoding and the
// index-width function used to size ranks and original-index fields.
package rank_sort_param_pkg;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_CMP  = 5'b00010,
        ST_SUM  = 5'b00100,
        ST_SCAT = 5'b01000,
        ST_HOLD = 5'b10000
    } state_e;

    // ceil(log2(n)); callers guarantee n >= 2
    function automatic int idx_width(input int n);
        int w;
        w = 32'sd0;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rank_sort_param_popcount.sv
// Combinational ones count of a DN-bit compare row, built as a balanced adder tree.
module rank_sort_param_popcount
    import rank_sort_param_pkg::*;
#(
    parameter int DN = 25,
    parameter int IW = 5
) (
    input  logic [DN-1:0] bits_i,
    output logic [IW-1:0] count_o
);

    localparam int LV = idx_width(DN);
    localparam int NP = 32'sd1 << LV;

    // Every node is only IW bits wide: sums wrap modulo 2^IW, and the final
    // count (at most DN-1, the diagonal being zero) fits, so the result is exact.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = NP >> l;
        logic [IW-1:0] s [N];
        if (l == 0) begin : g_leaf
            for (genvar k = 0; k < N; k++) begin : g_bit
                if (k < DN) begin : g_used
                    assign s[k] = IW'(bits_i[k]);
                end else begin : g_pad
                    assign s[k] = '0;
                end
            end
        end else begin : g_add
            for (genvar k = 0; k < N; k++) begin : g_pair
                assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
            end
        end
    end

    assign count_o = g_lvl[LV].s[0];

endmodule

// File: rtl/rank_sort_param.sv
// Parallel rank sorter: all-pairs compare, per-row popcount ranks, scatter to
// sorted order. Stable ties, ascending or descending, valid/ready on both sides.
module rank_sort_param
    import rank_sort_param_pkg::*;
#(
    parameter int DN = 25,
    parameter int DW = 8,
    localparam int IW = idx_width(DN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW*DN-1:0] in_data,
    input  logic             in_desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW*DN-1:0] out_data,
    output logic [IW*DN-1:0] out_idx,
    output logic [IW*DN-1:0] out_rank
);

    state_e           state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic             desc_q;
    logic             accept_s;
    logic [DW-1:0]    data_q [DN];
    logic [DN-1:0]    cmp_q  [DN];
    logic [DN-1:0]    cmp_s  [DN];
    logic [IW-1:0]    rank_q [DN];
    logic [IW-1:0]    cnt_s  [DN];
    logic [DW*DN-1:0] out_data_q, scat_data_s;
    logic [IW*DN-1:0] out_idx_q, scat_idx_s;
    logic [IW*DN-1:0] out_rank_q, scat_rank_s;

    assign accept_s  = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_rank  = out_rank_q;

    // Next-state logic for the frame sequence IDLE -> CMP -> SUM -> SCAT -> HOLD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_CMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMP:  state_d = ST_SUM;
            ST_SUM:  state_d = ST_SCAT;
            ST_SCAT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    // Frame capture on the accepting handshake only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_q <= 1'b0;
            for (int k = 32'sd0; k < DN; k++) begin
                data_q[k] <= '0;
            end
        end else if (accept_s) begin
            desc_q <= in_desc;
            for (int k = 32'sd0; k < DN; k++) begin
                data_q[k] <= in_data[k*DW +: DW];
            end
        end
    end

    // c[i][j] = 1 when sample j must precede sample i; equal keys keep input order
    always_comb begin
        for (int i = 32'sd0; i < DN; i++) begin
            cmp_s[i] = '0;
            for (int j = 32'sd0; j < DN; j++) begin
                if (i != j) begin
                    if (desc_q) begin
                        cmp_s[i][j] = (data_q[i] < data_q[j]) ||
                                      ((data_q[i] == data_q[j]) && (i > j));
                    end else begin
                        cmp_s[i][j] = (data_q[i] > data_q[j]) ||
                                      ((data_q[i] == data_q[j]) && (i > j));
                    end
                end else begin
                    cmp_s[i][j] = 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < DN; i++) begin : g_rank
        rank_sort_param_popcount #(
            .DN(DN),
            .IW(IW)
        ) u_popcount (
            .bits_i (cmp_q[i]),
            .count_o(cnt_s[i])
        );
    end

    // Compare matrix and rank registers, each loaded in its own FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 32'sd0; i < DN; i++) begin
                cmp_q[i]  <= '0;
                rank_q[i] <= '0;
            end
        end else begin
            for (int i = 32'sd0; i < DN; i++) begin
                if (state_q == ST_CMP) begin
                    cmp_q[i] <= cmp_s[i];
                end
                if (state_q == ST_SUM) begin
                    rank_q[i] <= cnt_s[i];
                end
            end
        end
    end

    // Scatter each sample to the output slot named by its rank
    always_comb begin
        scat_data_s = '0;
        scat_idx_s  = '0;
        scat_rank_s = '0;
        for (int i = 32'sd0; i < DN; i++) begin
            scat_data_s[int'(rank_q[i])*DW +: DW] = data_q[i];
            scat_idx_s[int'(rank_q[i])*IW +: IW]  = IW'(i);
            scat_rank_s[i*IW +: IW]               = rank_q[i];
        end
    end

    // Result registers; they stay frozen through HOLD and until the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_rank_q <= '0;
        end else if (state_q == ST_SCAT) begin
            out_data_q <= scat_data_s;
            out_idx_q  <= scat_idx_s;
            out_rank_q <= scat_rank_s;
        end
    end

endmodule

// File: tb/tb_rank_sort_param.sv
// Bench for rank_sort_param: directed table vectors and corner sequences on a
// DN=5 instance, randomized frames against a stable-sort model on DN=25.
module tb_rank_sort_param;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst5, in_valid5, in_ready5, in_desc5, out_valid5, out_ready5;
    logic [39:0]  in_data5, out_data5;
    logic [14:0]  out_idx5, out_rank5;

    logic         rst25, in_valid25, in_ready25, in_desc25, out_valid25, out_ready25;
    logic [199:0] in_data25, out_data25;
    logic [124:0] out_idx25, out_rank25;

    rank_sort_param #(.DN(5), .DW(8)) u_dut5 (
        .clk(clk), .rst(rst5), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .in_desc(in_desc5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_data(out_data5), .out_idx(out_idx5),
        .out_rank(out_rank5)
    );

    rank_sort_param #(.DN(25), .DW(8)) u_dut25 (
        .clk(clk), .rst(rst25), .in_valid(in_valid25), .in_ready(in_ready25),
        .in_data(in_data25), .in_desc(in_desc25), .out_valid(out_valid25),
        .out_ready(out_ready25), .out_data(out_data25), .out_idx(out_idx25),
        .out_rank(out_rank25)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d  [5];
        logic       desc;
        logic [7:0] ed [5];
        logic [2:0] ei [5];
        logic [2:0] er [5];
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stable sort by insertion: a sample goes in front of the first element that
    // must strictly follow it, so equal keys stay in input order.
    function automatic void ref_sort(input int n, input logic [255:0] din, input logic desc,
                                     output logic [255:0] od, output logic [255:0] oi,
                                     output logic [255:0] orank);
        int iw, pos, ix, pv;
        int v [32];
        int order [$];
        iw = $clog2(n);
        od = '0; oi = '0; orank = '0;
        for (int k = 0; k < n; k++) v[k] = int'(din[k*8 +: 8]);
        for (int k = 0; k < n; k++) begin
            pos = order.size();
            for (int p = 0; p < order.size(); p++) begin
                if (desc ? (v[order[p]] < v[k]) : (v[order[p]] > v[k])) begin
                    pos = p;
                    break;
                end
            end
            order.insert(pos, k);
        end
        for (int p = 0; p < n; p++) begin
            ix = order[p];
            pv = p;
            od[p*8 +: 8] = 8'(v[ix]);
            for (int b = 0; b < iw; b++) begin
                oi[p*iw + b]     = ix[b];
                orank[ix*iw + b] = pv[b];
            end
        end
    endfunction

    // Count edges from the accept edge (edge 1) until out_valid; junk on the
    // idle input of the big DUT while it is busy must be ignored.
    task automatic wait_valid(input bit big, output int edges);
        edges = 1;
        while (!(big ? out_valid25 : out_valid5) && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (big) begin
                in_valid25 = 1'($urandom_range(0, 1));
                for (int k = 0; k < 25; k++) in_data25[k*8 +: 8] = 8'($urandom);
                in_desc25 = 1'($urandom_range(0, 1));
            end
        end
        if (big) in_valid25 = 1'b0;
    endtask

    task automatic send5(input logic [39:0] d, input logic desc);
        check("accept_ready5", 256'(in_ready5), 256'(1));
        in_valid5 = 1'b1; in_data5 = d; in_desc5 = desc;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        in_data5  = 40'({$urandom(), $urandom()});
        in_desc5  = ~desc;
    endtask

    task automatic rand_frame5(output logic [39:0] d);
        for (int k = 0; k < 5; k++) d[k*8 +: 8] = 8'($urandom_range(0, 5) * 40);
    endtask

    initial begin
        logic [39:0]  fd, fd2, ed;
        logic [255:0] xd, xi, xr;
        logic [14:0]  ei, er;
        logic         fdesc, fdesc2;
        int           lat, s, r, ok;
        int           seen [25];

        tbl[0].d = '{8'd30, 8'd10, 8'd20, 8'd10, 8'd40}; tbl[0].desc = 1'b0;
        tbl[0].ed = '{8'd10, 8'd10, 8'd20, 8'd30, 8'd40};
        tbl[0].ei = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd4};
        tbl[0].er = '{3'd3, 3'd0, 3'd2, 3'd1, 3'd4};
        tbl[1].d = '{8'd30, 8'd10, 8'd20, 8'd10, 8'd40}; tbl[1].desc = 1'b1;
        tbl[1].ed = '{8'd40, 8'd30, 8'd20, 8'd10, 8'd10};
        tbl[1].ei = '{3'd4, 3'd0, 3'd2, 3'd1, 3'd3};
        tbl[1].er = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd0};
        for (int t = 2; t < 4; t++) begin
            tbl[t].d  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
            tbl[t].desc = (t == 3);
            tbl[t].ed = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
            tbl[t].ei = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
            tbl[t].er = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        end

        rst5 = 1'b1; rst25 = 1'b1;
        in_valid5 = 1'b0; in_data5 = '0; in_desc5 = 1'b0; out_ready5 = 1'b1;
        in_valid25 = 1'b0; in_data25 = '0; in_desc25 = 1'b0; out_ready25 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst5 = 1'b0; rst25 = 1'b0;
        #1;
        check("rst_in_ready5", 256'(in_ready5), 256'(1));
        check("rst_out_valid5", 256'(out_valid5), 256'(0));
        check("rst_outs5", 256'({out_data5, out_idx5, out_rank5}), 256'(0));
        check("rst_in_ready25", 256'(in_ready25), 256'(1));
        check("rst_out_valid25", 256'(out_valid25), 256'(0));
        check("rst_outs25", 256'(out_data25), 256'(0));
        @(posedge clk); #1;

        // Directed table: mixed keys with ties, both orders, all-equal frames
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 5; k++) begin
                fd[k*8 +: 8] = tbl[t].d[k];
                ed[k*8 +: 8] = tbl[t].ed[k];
                ei[k*3 +: 3] = tbl[t].ei[k];
                er[k*3 +: 3] = tbl[t].er[k];
            end
            send5(fd, tbl[t].desc);
            wait_valid(1'b0, lat);
            check("tbl_latency", 256'(lat), 256'(4));
            check("tbl_out_data", 256'(out_data5), 256'(ed));
            check("tbl_out_idx", 256'(out_idx5), 256'(ei));
            check("tbl_out_rank", 256'(out_rank5), 256'(er));
            @(posedge clk); #1;
            check("tbl_valid_drop", 256'(out_valid5), 256'(0));
            check("tbl_ready_back", 256'(in_ready5), 256'(1));
        end

        // Back-pressure in HOLD with a pending frame on the input
        out_ready5 = 1'b0;
        rand_frame5(fd); fdesc = 1'($urandom_range(0, 1));
        rand_frame5(fd2); fdesc2 = 1'($urandom_range(0, 1));
        send5(fd, fdesc);
        wait_valid(1'b0, lat);
        check("stall_latency", 256'(lat), 256'(4));
        ref_sort(5, 256'(fd), fdesc, xd, xi, xr);
        in_valid5 = 1'b1; in_data5 = fd2; in_desc5 = fdesc2;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("stall_valid", 256'(out_valid5), 256'(1));
            check("stall_no_ready", 256'(in_ready5), 256'(0));
            check("stall_data", 256'(out_data5), xd);
            check("stall_idx_rank", 256'({out_idx5, out_rank5}), (xi << 15) | xr);
        end
        out_ready5 = 1'b1;
        @(posedge clk); #1;
        check("release_valid_drop", 256'(out_valid5), 256'(0));
        check("release_in_ready", 256'(in_ready5), 256'(1));
        @(posedge clk); #1;
        check("release_accept", 256'(in_ready5), 256'(0));
        in_valid5 = 1'b0;
        wait_valid(1'b0, lat);
        check("release_latency", 256'(lat), 256'(4));
        ref_sort(5, 256'(fd2), fdesc2, xd, xi, xr);
        check("release_data", 256'(out_data5), xd);
        check("release_idx", 256'(out_idx5), xi);
        check("release_rank", 256'(out_rank5), xr);
        @(posedge clk); #1;

        // Reset pulse while the frame sits in SUM; outputs hold a prior result
        rand_frame5(fd);
        send5(fd, 1'b0);
        @(posedge clk); #1;
        rst5 = 1'b1;
        #1;
        check("midrst_valid", 256'(out_valid5), 256'(0));
        check("midrst_ready", 256'(in_ready5), 256'(1));
        check("midrst_outs", 256'({out_data5, out_idx5, out_rank5}), 256'(0));
        @(posedge clk); #1;
        rst5 = 1'b0;
        #1;
        check("postrst_ready", 256'(in_ready5), 256'(1));
        check("postrst_valid", 256'(out_valid5), 256'(0));
        rand_frame5(fd); fdesc = 1'b1;
        send5(fd, fdesc);
        wait_valid(1'b0, lat);
        check("postrst_latency", 256'(lat), 256'(4));
        ref_sort(5, 256'(fd), fdesc, xd, xi, xr);
        check("postrst_data", 256'(out_data5), xd);
        check("postrst_idx", 256'(out_idx5), xi);
        check("postrst_rank", 256'(out_rank5), xr);
        @(posedge clk); #1;

        // Randomized DN=25 frames, random order, narrow keys for ties, random stalls
        for (int f = 0; f < 1000; f++) begin
            logic [199:0] rd;
            logic         rdesc;
            r = $urandom_range(0, 2);
            for (int k = 0; k < 25; k++)
                rd[k*8 +: 8] = (r == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            rdesc = 1'($urandom_range(0, 1));
            s = $urandom_range(0, 3);
            out_ready25 = (s == 0);
            check("r_accept_ready", 256'(in_ready25), 256'(1));
            in_valid25 = 1'b1; in_data25 = rd; in_desc25 = rdesc;
            @(posedge clk); #1;
            wait_valid(1'b1, lat);
            ref_sort(25, 256'(rd), rdesc, xd, xi, xr);
            check("r_latency", 256'(lat), 256'(4));
            check("r_data", 256'(out_data25), xd);
            check("r_idx", 256'(out_idx25), xi);
            check("r_rank", 256'(out_rank25), xr);
            for (int k = 0; k < 25; k++) seen[k] = 0;
            for (int k = 0; k < 25; k++) begin
                r = int'(out_rank25[k*5 +: 5]);
                if (r < 25) seen[r]++;
            end
            ok = 1;
            for (int k = 0; k < 25; k++) if (seen[k] != 1) ok = 0;
            check("r_rank_perm", 256'(ok), 256'(1));
            for (int c = 0; c < s; c++) begin
                @(posedge clk); #1;
                check("r_stall_hold", 256'({out_valid25, out_data25}), 256'({1'b1, xd[199:0]}));
            end
            out_ready25 = 1'b1;
            @(posedge clk); #1;
            check("r_valid_drop", 256'(out_valid25), 256'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
